id_operand_unit: RTL and testbench
==================================

ID_OPERAND_UNIT -- requirements
Module: id_operand_unit

Interface
REQ-001 Parameter DATA_W, default 32, register and immediate width.
REQ-002 Parameter NREGS, default 32, number of architectural registers; address width is 5.
REQ-003 The block SHALL use one clock, clk, and an asynchronous, active-high reset, rst.
REQ-004 The block SHALL provide the following ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- instr_i  in  32  raw RV32I instruction word.
- format_i  in  3  instruction format code (core::format_t).
- imm_o  out  32  sign-extended immediate.
- i_raddr_a  in  5  read port A address.
- i_raddr_b  in  5  read port B address.
- i_wen  in  1  write enable.
- i_waddr  in  5  write address.
- i_wdata  in  32  write data.
- o_rdata_a  out  32  read port A data.
- o_rdata_b  out  32  read port B data.

Function
REQ-005 Format encoding SHALL be: NOP=0, R_FORMAT=1, I_FORMAT=2, S_FORMAT=3, B_FORMAT=4, U_FORMAT=5, J_FORMAT=6; code 7 is reserved.
REQ-006 imm_o SHALL be purely combinational from instr_i and format_i, with zero latency and no dependence on clk or rst.
REQ-007 imm_o by format:
- I: sext(instr[31:20]).
- S: sext({instr[31:25], instr[11:7]}).
- B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- U: {instr[31:12], 12'b0}.
- J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
REQ-008 When format_i is J_FORMAT and instr[6:0] is 7'b1100111 (JALR), imm_o SHALL use the I-type immediate.
REQ-009 For NOP, R_FORMAT or reserved codes, imm_o SHALL be 0.
REQ-010 Sign extension SHALL always replicate instr[31].
REQ-011 The register file SHALL hold NREGS x DATA_W registers.
- Two combinational read ports.
- One synchronous write port, written on the rising edge of clk when i_wen=1.
REQ-012 Register x0 SHALL always read 0; writes to address 0 SHALL be discarded.
REQ-013 Write-through bypass: when i_wen=1, i_waddr!=0 and a read address equals i_waddr, that port SHALL return i_wdata in the same cycle.
- Both ports may bypass simultaneously.
REQ-014 Reads of addresses other than the one being written SHALL return stored contents, unaffected by the concurrent write.
REQ-015 Consecutive writes to the same address SHALL resolve as last-edge-wins.

Reset
REQ-016 Asserting rst SHALL clear all registers to 0 immediately, without waiting for a clock edge.
- Any write in progress is aborted.
- o_rdata_a and o_rdata_b read 0 while rst=1, except for the combinational bypass of REQ-013.
REQ-017 While rst=1, no write SHALL take effect.
REQ-018 The first write SHALL occur on the first rising edge after rst deasserts.
REQ-019 imm_o SHALL be unaffected by rst.

Structure
REQ-020 The format codes, DATA_W and the register-address type SHALL live in the shared core package; the RV32I opcode constants SHALL live in the riscv package.
REQ-021 The register file SHALL be a sub-module named regfile_2r1w.
REQ-022 Immediate generation SHALL be a combinational block within id_operand_unit.

Verification
REQ-023 Immediate cases:
- instr 0xFFF00093, format I -> imm_o=0xFFFFFFFF.
- instr 0x0020A423, format S -> imm_o=0x00000008.
- instr 0x123452B7, format U -> imm_o=0x12345000.
REQ-024 Branch and jump immediates:
- instr 0xFE000EE3, format B -> imm_o=0xFFFFFFFC.
- instr 0x001000EF, format J -> imm_o=0x00000800.
- instr 0x00808067 (JALR), format J -> imm_o=0x00000008.
REQ-025 Write/read: write 0xDEADBEEF to x3, then read x3 on port A and on port B in the next cycle -> both return 0xDEADBEEF.
REQ-026 x0 protection: write 0x12345678 to x0 -> a subsequent read of x0 returns 0.
REQ-027 Bypass: i_wen=1, i_waddr=7, i_wdata=0xA5A5A5A5 with i_raddr_a=7 -> o_rdata_a=0xA5A5A5A5 before the clock edge.
REQ-028 Reset: load x1..x31, then assert rst mid-cycle -> all reads return 0 immediately, and a write issued during rst is ignored.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, register addressing and the
// instruction format codes produced by the decoder.
package core;

  localparam int DATA_W     = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Code 7 is reserved and decodes to a zero immediate.
  typedef enum logic [2:0] {
    NOP      = 3'd0,
    R_FORMAT = 3'd1,
    I_FORMAT = 3'd2,
    S_FORMAT = 3'd3,
    B_FORMAT = 3'd4,
    U_FORMAT = 3'd5,
    J_FORMAT = 3'd6,
    FMT_RSVD = 3'd7
  } format_t;

endpackage

// File: rtl/riscv_pkg.sv
// RV32I base opcode constants (instr[6:0]).
package riscv;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with x0 hard-wired to zero,
// write-through bypass on both read ports and asynchronous clear.
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     i_raddr_a,
  input  logic [AW-1:0]     i_raddr_b,
  input  logic              i_wen,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wr_en;

  // Writes to x0 or to addresses beyond the implemented file are dropped.
  assign wr_en = i_wen && (i_waddr != '0) && (int'(i_waddr) < NREGS);

  // Bypass wins over storage; stored data is masked while rst is held so
  // the clear is visible even before the reset NBA has landed.
  function automatic logic [DATA_W-1:0] rd_port(input logic [AW-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    if (i_wen && (addr == i_waddr) && (addr != '0))
      val = i_wdata;
    else if (!rst && (addr != '0) && (int'(addr) < NREGS))
      val = regs_q[addr];
    return val;
  endfunction

  // Storage: asynchronous clear, single synchronous write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[i_waddr] <= i_wdata;
    end
  end

  // Combinational read ports.
  always_comb begin
    o_rdata_a = rd_port(i_raddr_a);
    o_rdata_b = rd_port(i_raddr_b);
  end

endmodule

// File: rtl/id_operand_unit.sv
// Decode-stage operand unit: RV32I immediate generation plus the
// architectural register file.
module id_operand_unit #(
  parameter int DATA_W = core::DATA_W,
  parameter int NREGS  = core::NREGS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 instr_i,
  input  logic [2:0]                  format_i,
  output logic [31:0]                 imm_o,
  input  logic [core::REG_ADDR_W-1:0] i_raddr_a,
  input  logic [core::REG_ADDR_W-1:0] i_raddr_b,
  input  logic                        i_wen,
  input  logic [core::REG_ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0]           i_wdata,
  output logic [DATA_W-1:0]           o_rdata_a,
  output logic [DATA_W-1:0]           o_rdata_b
);

  import riscv::*;

  core::format_t fmt;
  logic [31:0]   imm_i;
  logic [31:0]   imm_s;
  logic [31:0]   imm_b;
  logic [31:0]   imm_u;
  logic [31:0]   imm_j;

  assign fmt = core::format_t'(format_i);

  // All immediates sign-extend from instr[31].
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};

  // Immediate select; JALR is tagged as a jump but carries an I-type field.
  always_comb begin
    imm_o = '0;
    case (fmt)
      core::I_FORMAT: imm_o = imm_i;
      core::S_FORMAT: imm_o = imm_s;
      core::B_FORMAT: imm_o = imm_b;
      core::U_FORMAT: imm_o = imm_u;
      core::J_FORMAT: imm_o = (instr_i[6:0] == OPC_JALR) ? imm_i : imm_j;
      default:        imm_o = '0;
    endcase
  end

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (core::REG_ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_raddr_a (i_raddr_a),
    .i_raddr_b (i_raddr_b),
    .i_wen     (i_wen),
    .i_waddr   (i_waddr),
    .i_wdata   (i_wdata),
    .o_rdata_a (o_rdata_a),
    .o_rdata_b (o_rdata_b)
  );

endmodule

// File: tb/tb_id_operand_unit.sv
// Directed bench for id_operand_unit with a queue-based scoreboard.
module tb_id_operand_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [2:0]  format;
  logic [31:0] imm;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;

  typedef struct {
    string       name;
    int          sel;   // 0: imm_o, 1: o_rdata_a, 2: o_rdata_b
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  event chk_ev;
  int   n_checks = 0;
  int   n_fail   = 0;

  id_operand_unit dut (
    .clk       (clk),
    .rst       (rst),
    .instr_i   (instr),
    .format_i  (format),
    .imm_o     (imm),
    .i_raddr_a (raddr_a),
    .i_raddr_b (raddr_b),
    .i_wen     (wen),
    .i_waddr   (waddr),
    .i_wdata   (wdata),
    .o_rdata_a (rdata_a),
    .o_rdata_b (rdata_b)
  );

  always #5 clk = ~clk;

  // Monitor: pops expectations and compares against the presented outputs.
  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.sel)
          0:       act = imm;
          1:       act = rdata_a;
          default: act = rdata_b;
        endcase
        n_checks++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb_q.push_back(e);
    -> chk_ev;
    for (int k = 0; k < 4; k++) begin
      if (sb_q.size() == 0) break;
      #1;
    end
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: monitor timeout, %0d pending, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic imm_case(input string name, input logic [31:0] ins,
                          input logic [2:0] fmt, input logic [31:0] exp);
    instr  = ins;
    format = fmt;
    #1;
    expect_val(name, 0, exp);
  endtask

  task automatic read_a(input string name, input logic [4:0] a, input logic [31:0] exp);
    raddr_a = a;
    #1;
    expect_val(name, 1, exp);
  endtask

  task automatic read_b(input string name, input logic [4:0] a, input logic [31:0] exp);
    raddr_b = a;
    #1;
    expect_val(name, 2, exp);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wen   = 1'b1;
    waddr = a;
    wdata = d;
    @(negedge clk);
    wen   = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1; instr = '0; format = '0;
    raddr_a = '0; raddr_b = '0; wen = 1'b0; waddr = '0; wdata = '0;
    #12;

    // Reset state and immediate path independent of rst
    imm_case("imm_I_during_rst", 32'hFFF00093, 3'd2, 32'hFFFFFFFF);
    read_a("rst_read_a", 5'd5, 32'h0);
    read_b("rst_read_b", 5'd31, 32'h0);

    // Write attempted during rst: bypass visible, storage untouched
    @(negedge clk);
    wen = 1'b1; waddr = 5'd4; wdata = 32'h44444444;
    read_a("rst_bypass", 5'd4, 32'h44444444);
    @(negedge clk);
    wen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    read_a("no_write_during_rst", 5'd4, 32'h0);

    // Immediate formats
    imm_case("imm_S",        32'h0020A423, 3'd3, 32'h00000008);
    imm_case("imm_U",        32'h123452B7, 3'd5, 32'h12345000);
    imm_case("imm_U_neg",    32'h800000B7, 3'd5, 32'h80000000);
    imm_case("imm_B",        32'hFE000EE3, 3'd4, 32'hFFFFFFFC);
    imm_case("imm_J",        32'h001000EF, 3'd6, 32'h00000800);
    imm_case("imm_JALR",     32'h00808067, 3'd6, 32'h00000008);
    imm_case("imm_NOP",      32'hFFFFFFFF, 3'd0, 32'h0);
    imm_case("imm_R",        32'hFFFFFFFF, 3'd1, 32'h0);
    imm_case("imm_reserved", 32'hFFFFFFFF, 3'd7, 32'h0);

    // Basic write then read on both ports
    write_reg(5'd3, 32'hDEADBEEF);
    read_a("x3_port_a", 5'd3, 32'hDEADBEEF);
    read_b("x3_port_b", 5'd3, 32'hDEADBEEF);

    // x0 protection, stored and bypass paths
    write_reg(5'd0, 32'h12345678);
    read_a("x0_after_write", 5'd0, 32'h0);
    @(negedge clk);
    wen = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
    read_a("x0_no_bypass", 5'd0, 32'h0);
    @(negedge clk);
    wen = 1'b0;

    // Bypass on both ports before the edge, then stored value after
    @(negedge clk);
    wen = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
    raddr_a = 5'd7; raddr_b = 5'd7;
    #1;
    expect_val("bypass_a", 1, 32'hA5A5A5A5);
    expect_val("bypass_b", 2, 32'hA5A5A5A5);
    @(negedge clk);
    wen = 1'b0;
    read_a("x7_stored", 5'd7, 32'hA5A5A5A5);

    // Other address unaffected by a concurrent write
    @(negedge clk);
    wen = 1'b1; waddr = 5'd9; wdata = 32'h99999999;
    raddr_a = 5'd3; raddr_b = 5'd9;
    #1;
    expect_val("unaffected_x3", 1, 32'hDEADBEEF);
    expect_val("bypass_x9",     2, 32'h99999999);
    @(negedge clk);
    wen = 1'b0;

    // Last edge wins
    @(negedge clk);
    wen = 1'b1; waddr = 5'd10; wdata = 32'h00000001;
    @(negedge clk);
    wdata = 32'h00000002;
    @(negedge clk);
    wen = 1'b0;
    read_a("last_edge_wins", 5'd10, 32'h00000002);

    // Load x1..x31 back to back
    @(negedge clk);
    wen = 1'b1;
    for (int i = 1; i < 32; i++) begin
      waddr = 5'(i);
      wdata = 32'hC0000000 | 32'(i);
      @(negedge clk);
    end
    wen = 1'b0;
    read_a("load_x1",  5'd1,  32'hC0000001);
    read_b("load_x31", 5'd31, 32'hC000001F);

    // Mid-cycle asynchronous reset clears immediately
    raddr_a = 5'd1; raddr_b = 5'd31;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    expect_val("async_clear_a", 1, 32'h0);
    expect_val("async_clear_b", 2, 32'h0);

    // Write issued while rst is held
    @(negedge clk);
    wen = 1'b1; waddr = 5'd5; wdata = 32'h55555555;
    @(negedge clk);
    wen = 1'b0;
    for (int i = 1; i < 32; i++)
      read_a($sformatf("rst_clear_x%0d", i), 5'(i), 32'h0);

    // First write lands on the first edge after rst deasserts
    @(negedge clk);
    rst = 1'b0;
    wen = 1'b1; waddr = 5'd6; wdata = 32'h66666666;
    @(negedge clk);
    wen = 1'b0;
    read_a("first_write_after_rst", 5'd6, 32'h66666666);
    for (int i = 1; i < 32; i++)
      if (i != 6) read_b($sformatf("post_rst_x%0d", i), 5'(i), 32'h0);

    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
